// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_ctrl_if : push/pop handshake, register_file addressing and status     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
interface fifo_ctrl_if #(
  parameter int W = 3
);
  logic         wr;
  logic         rd;
  logic         clr_err;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [W-1:0] r_addr;
  logic [W:0]   count;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic         overflow;
  logic         underflow;

  modport master (
    output wr, rd, clr_err,
    input  wr_en, w_addr, r_addr, count, full, empty,
    input  almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr, rd, clr_err,
    output wr_en, w_addr, r_addr, count, full, empty,
    output almost_full, almost_empty, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_ctrl : pointer/flag controller turning a register file into a FIFO   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module fifo_ctrl #(
  parameter int W      = 3,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 1
) (
  input  logic       clk,
  input  logic       rst,
  fifo_ctrl_if.slave bus
);
  localparam logic [W:0] c_DEPTH = (W+1)'(1 << W);
  localparam logic [W:0] c_AF    = (W+1)'(AF_LVL);
  localparam logic [W:0] c_AE    = (W+1)'(AE_LVL);

  logic [W-1:0] r_wptr;
  logic [W-1:0] r_rptr;
  logic [W:0]   r_count;
  logic         r_overflow;
  logic         r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign w_push_ok = bus.wr & (~w_full | bus.rd);
  assign w_pop_ok  = bus.rd & ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + W'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + W'(1);

      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (W+1)'(1);
        2'b01:   r_count <= r_count - (W+1)'(1);
        default: r_count <= r_count;
      endcase

      // A fresh error outranks a simultaneous clear.
      if (bus.wr & ~w_push_ok) r_overflow <= 1'b1;
      else if (bus.clr_err)    r_overflow <= 1'b0;

      if (bus.rd & ~w_pop_ok)  r_underflow <= 1'b1;
      else if (bus.clr_err)    r_underflow <= 1'b0;
    end
  end

  // Gate with reset so the register file is never written while held in reset.
  assign bus.wr_en        = rst & w_push_ok;
  assign bus.w_addr       = r_wptr;
  assign bus.r_addr       = r_rptr;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= c_AF);
  assign bus.almost_empty = (r_count <= c_AE);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire
